// File: rtl/equiv_miter_sequencer.sv
// Stimulus and result controller for a dual-instance equivalence miter.
// LFSR-driven input vectors, warm-up window, then cycle-by-cycle compare of y_1 against y_2.
module equiv_miter_sequencer #(
    parameter int unsigned IN_W        = 94,
    parameter int unsigned OUT_W       = 91,
    parameter int unsigned NUM_VECTORS = 1024,
    parameter int unsigned WARMUP      = 4,
    parameter logic [31:0] SEED        = 32'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] y_1,
    input  logic [OUT_W-1:0] y_2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [31:0]      mismatch_cycle,
    output logic [OUT_W-1:0] mismatch_xor,
    output logic [31:0]      vec_count
);

    localparam int unsigned NWORDS   = (IN_W + 31) / 32;
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] GOLDEN    = 32'h9E37_79B9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_RUN,
        S_DONE,
        S_FAIL
    } state_t;

    state_t      state, state_next;
    logic [31:0] lfsr;
    logic [31:0] lfsr_next;
    logic [31:0] warm_cnt;
    logic        load, clr, step, count, capture, differ;

    // Each 32-bit slice of the bus is the LFSR word XORed with a per-slice constant
    function automatic logic [IN_W-1:0] expand(input logic [31:0] s);
        logic [32*NWORDS-1:0] wide;
        wide = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            wide[32*i +: 32] = s ^ (i * GOLDEN);
        end
        return wide[IN_W-1:0];
    endfunction

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'h0);
    assign differ    = |(y_1 ^ y_2);

    always_comb begin
        state_next = state;
        load       = 1'b0;
        clr        = 1'b0;
        step       = 1'b0;
        count      = 1'b0;
        capture    = 1'b0;
        if (abort) begin
            state_next = S_IDLE;
            clr        = 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        state_next = (WARMUP == 0) ? S_RUN : S_WARM;
                        load       = 1'b1;
                    end
                end
                S_WARM: begin
                    step = 1'b1;
                    if (warm_cnt == 32'(WARMUP - 1)) state_next = S_RUN;
                end
                S_RUN: begin
                    step = 1'b1;
                    // A difference on the last compare still lands in FAIL
                    if (differ) begin
                        capture    = 1'b1;
                        state_next = S_FAIL;
                    end else begin
                        count = (vec_count != 32'(NUM_VECTORS));
                        if (vec_count == 32'(NUM_VECTORS - 1)) state_next = S_DONE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            lfsr           <= SEED_EFF;
            dut_in         <= '0;
            warm_cnt       <= '0;
            vec_count      <= '0;
            mismatch_cycle <= '0;
            mismatch_xor   <= '0;
        end else begin
            state <= state_next;
            if (clr || load) begin
                lfsr           <= SEED_EFF;
                dut_in         <= '0;
                warm_cnt       <= '0;
                vec_count      <= '0;
                mismatch_cycle <= '0;
                mismatch_xor   <= '0;
            end else begin
                if (step) begin
                    lfsr   <= lfsr_next;
                    dut_in <= expand(lfsr);
                end
                if (step && state == S_WARM) warm_cnt <= warm_cnt + 32'd1;
                if (count) vec_count <= vec_count + 32'd1;
                if (capture) begin
                    mismatch_cycle <= vec_count;
                    mismatch_xor   <= y_1 ^ y_2;
                end
            end
        end
    end

    assign busy = (state == S_WARM) || (state == S_RUN);
    assign done = (state == S_DONE) || (state == S_FAIL);
    assign pass = (state == S_DONE);
    assign fail = (state == S_FAIL);

endmodule
